// File: rtl/gcd_ctrl.sv
// gcd_ctrl: sequencer for a repeated-subtraction GCD datapath.
//
// Captures two operands on a start handshake. One shared subtractor then
// computes larger-minus-smaller on each edge until the operands are equal
// or one of them is zero. The block reports the GCD, the number of
// subtractions (saturating) and a one-cycle done pulse.
//
// Ports
//   clk       in   1      clock, all state changes on the rising edge
//   rst_n     in   1      synchronous reset, active low
//   start     in   1      job request, sampled only while IDLE
//   A_IN      in   WIDTH  operand A, captured with start
//   B_IN      in   WIDTH  operand B, captured with start
//   busy      out  1      high in RUN and DONE
//   done      out  1      one-cycle pulse, GCD_OUT/ITER_CNT valid
//   GCD_OUT   out  WIDTH  result, held until the next result is written
//   ITER_CNT  out  CNT_W  subtraction count, saturates at all-ones
module gcd_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] GCD_OUT,
    output logic [CNT_W-1:0] ITER_CNT
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;

    // Datapath status
    logic a_eq_b;
    logic a_zero;
    logic b_zero;
    logic a_gt_b;
    logic finish;

    // Shared subtractor
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic [WIDTH-1:0] diff;

    // Control strobes from the output decoder
    logic load_ops;
    logic wr_gcd;
    logic gcd_from_b;
    logic step;

    always_comb begin
        a_eq_b = (reg_a == reg_b);
        a_zero = (reg_a == '0);
        b_zero = (reg_b == '0);
        a_gt_b = (reg_a > reg_b);
        finish = a_eq_b | a_zero | b_zero;
    end

    // The larger operand is always the minuend, so the difference never wraps.
    always_comb begin
        minuend    = a_gt_b ? reg_a : reg_b;
        subtrahend = a_gt_b ? reg_b : reg_a;
        diff       = minuend - subtrahend;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start  ? RUN  : IDLE;
            RUN:     state_nxt = finish ? DONE : RUN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        load_ops   = 1'b0;
        wr_gcd     = 1'b0;
        gcd_from_b = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                load_ops = start;
            end
            RUN: begin
                busy = 1'b1;
                // Priority: equal, A zero, B zero, then subtract.
                // (0,0) resolves through the equality branch to 0.
                if (a_eq_b) begin
                    wr_gcd = 1'b1;
                end else if (a_zero) begin
                    wr_gcd     = 1'b1;
                    gcd_from_b = 1'b1;
                end else if (b_zero) begin
                    wr_gcd = 1'b1;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand, result and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_a    <= '0;
            reg_b    <= '0;
            GCD_OUT  <= '0;
            ITER_CNT <= '0;
        end else begin
            if (load_ops) begin
                reg_a    <= A_IN;
                reg_b    <= B_IN;
                ITER_CNT <= '0;
            end
            if (wr_gcd) begin
                GCD_OUT <= gcd_from_b ? reg_b : reg_a;
            end
            if (step) begin
                if (a_gt_b) begin
                    reg_a <= diff;
                end else begin
                    reg_b <= diff;
                end
                if (ITER_CNT != '1) begin
                    ITER_CNT <= ITER_CNT + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: self-checking bench for gcd_ctrl.
// A second instance with a 4-bit counter shares all stimulus so counter
// saturation is observable with 8-bit operands.
module tb_gcd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;

    logic       busy;
    logic       done;
    logic [7:0] gcd;
    logic [7:0] cnt;

    logic       busy_s;
    logic       done_s;
    logic [7:0] gcd_s;
    logic [3:0] cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    gcd_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A_IN(a_in), .B_IN(b_in),
        .busy(busy), .done(done), .GCD_OUT(gcd), .ITER_CNT(cnt)
    );

    gcd_ctrl #(.WIDTH(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .A_IN(a_in), .B_IN(b_in),
        .busy(busy_s), .done(done_s), .GCD_OUT(gcd_s), .ITER_CNT(cnt_s)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: Euclid by division. The subtraction count is the sum of
    // the quotients, minus one because the last subtraction stops at a==b.
    function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                    output int unsigned g, output int unsigned n);
        int unsigned x, y, r;
        if (a == 0 || b == 0) begin
            g = (a == 0) ? b : a;
            n = 0;
        end else begin
            x = (a > b) ? a : b;
            y = (a > b) ? b : a;
            n = 0;
            while (y != 0) begin
                n += x / y;
                r  = x % y;
                x  = y;
                y  = r;
            end
            g = x;
            n = n - 1;
        end
    endfunction

    function automatic int unsigned sat15(input int unsigned n);
        return (n > 15) ? 15 : n;
    endfunction

    // mode 0: leave inputs alone; 1: pulse start with 5/3 at the second
    // edge after accept; 2: random junk on start/A/B every cycle.
    task automatic wait_done(input int unsigned exp_lat, input int mode, input string tag);
        int unsigned k = 0;
        while (done !== 1'b1 && k < 400) begin
            if (mode == 1) begin
                start = (k == 1);
                a_in  = 8'd5;
                b_in  = 8'd3;
            end else if (mode == 2) begin
                start = 1'($urandom_range(0, 1));
                a_in  = 8'($urandom_range(0, 255));
                b_in  = 8'($urandom_range(0, 255));
            end
            tick();
            k++;
        end
        check_eq({tag, " latency"}, k, exp_lat);
    endtask

    task automatic check_result(input string tag, input int unsigned g, input int unsigned n);
        check_eq({tag, " gcd"},    gcd,    g);
        check_eq({tag, " cnt"},    cnt,    n);
        check_eq({tag, " busy"},   busy,   1);
        check_eq({tag, " gcd_s"},  gcd_s,  g);
        check_eq({tag, " cnt_s"},  cnt_s,  sat15(n));
        check_eq({tag, " done_s"}, done_s, 1);
    endtask

    task automatic check_idle(input string tag, input int unsigned g, input int unsigned n);
        check_eq({tag, " idle done"}, done, 0);
        check_eq({tag, " idle busy"}, busy, 0);
        check_eq({tag, " hold gcd"},  gcd,  g);
        check_eq({tag, " hold cnt"},  cnt,  n);
        check_eq({tag, " idle done_s"}, done_s, 0);
    endtask

    task automatic run_job(input int unsigned a, input int unsigned b, input int mode, input string tag);
        int unsigned g, n;
        ref_gcd(a, b, g, n);
        start = 1'b1;
        a_in  = 8'(a);
        b_in  = 8'(b);
        tick();
        start = 1'b0;
        check_eq({tag, " accept busy"}, busy, 1);
        check_eq({tag, " accept cnt"},  cnt,  0);
        wait_done(n + 1, mode, tag);
        check_result(tag, g, n);
        // start during DONE must not be taken
        start = (mode != 0);
        tick();
        start = 1'b0;
        check_idle(tag, g, n);
    endtask

    initial begin
        int unsigned g, n, a, b, sel;
        int mode;

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) tick();
        check_eq("reset busy", busy, 0);
        check_eq("reset done", done, 0);
        check_eq("reset gcd",  gcd,  0);
        check_eq("reset cnt",  cnt,  0);
        check_eq("reset busy_s", busy_s, 0);
        rst_n = 1'b1;
        tick();
        check_eq("post-reset busy", busy, 0);

        // Directed cases
        run_job(48, 18, 0, "t1");
        run_job(0, 9, 0, "t2a");
        run_job(0, 0, 0, "t2b");
        run_job(9, 0, 0, "t2c");
        run_job(7, 7, 0, "t3a");
        run_job(1, 255, 0, "t3b");
        run_job(48, 18, 1, "t4 ignore");

        // Back-to-back with start held: second job accepted once IDLE is reached
        start = 1'b1;
        a_in  = 8'd48;
        b_in  = 8'd18;
        tick();
        a_in  = 8'd12;
        b_in  = 8'd8;
        wait_done(5, 0, "t4 b2b first");
        check_result("t4 b2b first", 6, 4);
        tick();
        check_eq("t4 b2b gap busy", busy, 0);
        check_eq("t4 b2b gap done", done, 0);
        tick();
        start = 1'b0;
        check_eq("t4 b2b accept busy", busy, 1);
        check_eq("t4 b2b accept cnt",  cnt,  0);
        wait_done(3, 0, "t4 b2b second");
        check_result("t4 b2b second", 4, 2);
        tick();
        check_idle("t4 b2b second", 4, 2);

        // Reset in the middle of a job
        start = 1'b1;
        a_in  = 8'd100;
        b_in  = 8'd75;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("t5 rst busy", busy, 0);
        check_eq("t5 rst done", done, 0);
        check_eq("t5 rst gcd",  gcd,  0);
        check_eq("t5 rst cnt",  cnt,  0);
        rst_n = 1'b1;
        tick();
        check_eq("t5 idle busy", busy, 0);
        check_eq("t5 idle gcd",  gcd,  0);
        run_job(100, 75, 0, "t5 rerun");

        // Randomized jobs against the reference model
        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom_range(0, 255);
            b   = $urandom_range(0, 255);
            if (sel == 0) a = 0;
            else if (sel == 1) b = 0;
            else if (sel == 2) b = a;
            else if (sel == 3) a = $urandom_range(1, 3);
            mode = (sel >= 7) ? 2 : 0;
            run_job(a, b, mode, "rand");
            if ((i % 8) == 0) begin
                // idle cycles with noisy operands must not disturb outputs
                ref_gcd(a, b, g, n);
                a_in = 8'($urandom_range(0, 255));
                b_in = 8'($urandom_range(0, 255));
                tick();
                check_idle("rand idle", g, n);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
